// File: rtl/sys_serv_sequencer_pkg.sv
// Shared types and constants for the system-services front-end sequencer.
package sys_serv_pkg;

  localparam int OPC_W  = 8;
  localparam int STAT_W = 8;
  localparam int TO_W   = 24;

  localparam logic [31:0] CMD_ADDR_DEF  = 32'h0000_0000;
  localparam logic [31:0] STAT_ADDR_DEF = 32'h0000_0004;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_ACCESS,
    BUSY_WAIT,
    RD_SETUP,
    RD_ACCESS,
    RESP
  } state_t;

  function automatic logic [31:0] cmd_word(
    input logic [OPC_W-1:0] op
  );
    return {{(32-OPC_W){1'b0}}, op};
  endfunction

endpackage

// File: rtl/sys_serv_sequencer_if.sv
// Requester handshake, APB master and services-core status bundle.
interface sys_serv_sequencer_if #(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_opcode;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_status;
  logic                 rsp_error;
  logic                 rsp_timeout;

  logic        APBM_PSEL;
  logic        APBM_PENABLE;
  logic        APBM_PWRITE;
  logic [31:0] APBM_PADDR;
  logic [31:0] APBM_PWDATA;
  logic [31:0] APBM_PRDATA;
  logic        APBM_PREADY;
  logic        APBM_PSLVERR;

  logic USR_BUSY;
  logic USR_CMD_ERROR;
  logic seq_busy;

  modport master (
    input  req_valid, req_opcode,
    input  APBM_PRDATA, APBM_PREADY, APBM_PSLVERR,
    input  USR_BUSY, USR_CMD_ERROR,
    output req_ack, rsp_valid,
    output rsp_status, rsp_error, rsp_timeout,
    output APBM_PSEL, APBM_PENABLE, APBM_PWRITE,
    output APBM_PADDR, APBM_PWDATA,
    output seq_busy
  );

  modport slave (
    output req_valid, req_opcode,
    output APBM_PRDATA, APBM_PREADY, APBM_PSLVERR,
    output USR_BUSY, USR_CMD_ERROR,
    input  req_ack, rsp_valid,
    input  rsp_status, rsp_error, rsp_timeout,
    input  APBM_PSEL, APBM_PENABLE, APBM_PWRITE,
    input  APBM_PADDR, APBM_PWDATA,
    input  seq_busy
  );

endinterface

// File: rtl/sys_serv_sequencer_arb.sv
// Combinational round-robin arbiter; the caller owns last_grant.
module sys_serv_rr_arb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(last) + i) % N);
      if (en && !found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/sys_serv_sequencer.sv
// Arbitrates service requests and runs APB command write, busy wait, status read.
module sys_serv_sequencer
  import sys_serv_pkg::*;
#(
  parameter int               NUM_REQ     = 2,
  parameter logic [31:0]      CMD_ADDR    = CMD_ADDR_DEF,
  parameter logic [31:0]      STAT_ADDR   = STAT_ADDR_DEF,
  parameter int               GUARD_CYC   = 2,
  parameter logic [TO_W-1:0]  TIMEOUT_CYC = 24'd1_000_000
) (
  input logic                  CLK,
  input logic                  RESETN,
  sys_serv_sequencer_if.master bus
);

  localparam int IW = $clog2(NUM_REQ);

  state_t state, state_nxt;

  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      winner;
  logic [IW-1:0]      arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [OPC_W-1:0]   opcode;
  logic [OPC_W-1:0]   sel_op;
  logic [TO_W-1:0]    cnt;
  logic [TO_W:0]      cnt_inc;
  logic [STAT_W-1:0]  status;
  logic err_acc, to_flag;
  logic rsp_error_q, rsp_timeout_q;
  logic arb_en, bw_done, to_hit;
  logic wr_ph, rd_ph;

  // Reset gates the grant so no ack escapes while held in reset.
  assign arb_en = (state == IDLE) && RESETN;

  sys_serv_rr_arb #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req  (bus.req_valid),
    .last (last_grant),
    .en   (arb_en),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_op = bus.req_opcode[i*OPC_W +: OPC_W];
      end
    end
  end

  // cnt_inc counts BUSY_WAIT cycles including the current one.
  assign cnt_inc = {1'b0, cnt} + {{TO_W{1'b0}}, 1'b1};
  assign bw_done = (cnt_inc >= (TO_W+1)'(GUARD_CYC))
                 && !bus.USR_BUSY;
  assign to_hit  = cnt_inc >= {1'b0, TIMEOUT_CYC};

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (|arb_gnt) state_nxt = WR_SETUP;
      WR_SETUP:  state_nxt = WR_ACCESS;
      WR_ACCESS: if (bus.APBM_PREADY) state_nxt = BUSY_WAIT;
      BUSY_WAIT: if (bw_done || to_hit) state_nxt = RD_SETUP;
      RD_SETUP:  state_nxt = RD_ACCESS;
      RD_ACCESS: if (bus.APBM_PREADY) state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state         <= IDLE;
      last_grant    <= IW'(NUM_REQ-1);
      winner        <= '0;
      opcode        <= '0;
      cnt           <= '0;
      err_acc       <= 1'b0;
      to_flag       <= 1'b0;
      status        <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == BUSY_WAIT && state_nxt == BUSY_WAIT) begin
        if (cnt != '1) cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      unique case (state)
        IDLE: begin
          if (|arb_gnt) begin
            winner <= arb_idx;
            opcode <= sel_op;
          end
        end
        WR_ACCESS: begin
          if (bus.APBM_PREADY) err_acc <= bus.APBM_PSLVERR;
        end
        BUSY_WAIT: begin
          if (to_hit && !bw_done) to_flag <= 1'b1;
        end
        RD_ACCESS: begin
          if (bus.APBM_PREADY) begin
            status        <= bus.APBM_PRDATA[STAT_W-1:0];
            rsp_error_q   <= err_acc | bus.APBM_PSLVERR
                           | bus.USR_CMD_ERROR | to_flag;
            rsp_timeout_q <= to_flag;
          end
        end
        RESP: begin
          last_grant <= winner;
          err_acc    <= 1'b0;
          to_flag    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign wr_ph = (state == WR_SETUP) || (state == WR_ACCESS);
  assign rd_ph = (state == RD_SETUP) || (state == RD_ACCESS);

  always_comb begin
    bus.APBM_PSEL    = 1'b0;
    bus.APBM_PENABLE = 1'b0;
    bus.APBM_PWRITE  = 1'b0;
    bus.APBM_PADDR   = '0;
    bus.APBM_PWDATA  = '0;
    unique case (1'b1)
      wr_ph: begin
        bus.APBM_PSEL    = 1'b1;
        bus.APBM_PENABLE = (state == WR_ACCESS);
        bus.APBM_PWRITE  = 1'b1;
        bus.APBM_PADDR   = CMD_ADDR;
        bus.APBM_PWDATA  = cmd_word(opcode);
      end
      rd_ph: begin
        bus.APBM_PSEL    = 1'b1;
        bus.APBM_PENABLE = (state == RD_ACCESS);
        bus.APBM_PADDR   = STAT_ADDR;
      end
      default: ;
    endcase
  end

  assign bus.req_ack     = arb_gnt;
  assign bus.rsp_valid   = (state == RESP)
                         ? (NUM_REQ'(1'b1) << winner) : '0;
  assign bus.rsp_status  = status;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.seq_busy    = (state != IDLE);

endmodule

// File: tb/tb_sys_serv_sequencer.sv
// Directed bench: APB slave model, busy stub and cycle-stamped monitor.
module tb_sys_serv_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sys_serv_sequencer_if #(.NUM_REQ(2)) bus();

  sys_serv_sequencer #(
    .NUM_REQ     (2),
    .CMD_ADDR    (32'h0000_0000),
    .STAT_ADDR   (32'h0000_0004),
    .GUARD_CYC   (2),
    .TIMEOUT_CYC (24'd100)
  ) dut (
    .CLK    (clk),
    .RESETN (rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0, n_ack = 0, n_rsp = 0, n_wr = 0, n_rd = 0;
  int ack_cyc = 0, rsp_cyc = 0, wr_cyc = 0, rd_setup_cyc = 0;
  logic [1:0]  ack_vec = '0, rsp_vec = '0;
  logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;

  int busy_cnt = 0, busy_len = 0;
  logic busy_stuck = 1'b0, pslverr_wr = 1'b0, cmd_err = 1'b0;
  logic [31:0] prdata = '0;

  assign bus.USR_BUSY      = busy_stuck | (busy_cnt != 0);
  assign bus.USR_CMD_ERROR = cmd_err;
  assign bus.APBM_PREADY   = 1'b1;
  assign bus.APBM_PRDATA   = prdata;
  assign bus.APBM_PSLVERR  = pslverr_wr & bus.APBM_PWRITE;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (|bus.req_ack) begin
      ack_cyc <= cyc;
      ack_vec <= bus.req_ack;
      n_ack   <= n_ack + 1;
    end
    if (|bus.rsp_valid) begin
      rsp_cyc <= cyc;
      rsp_vec <= bus.rsp_valid;
      n_rsp   <= n_rsp + 1;
    end
    if (bus.APBM_PSEL && !bus.APBM_PENABLE && !bus.APBM_PWRITE)
      rd_setup_cyc <= cyc;
    if (bus.APBM_PSEL && bus.APBM_PENABLE && bus.APBM_PREADY) begin
      if (bus.APBM_PWRITE) begin
        wr_addr  <= bus.APBM_PADDR;
        wr_data  <= bus.APBM_PWDATA;
        wr_cyc   <= cyc;
        n_wr     <= n_wr + 1;
        busy_cnt <= busy_len;
      end else begin
        rd_addr <= bus.APBM_PADDR;
        n_rd    <= n_rd + 1;
      end
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_ack(input int target);
    int b = 0;
    while (n_ack < target && b < 20) begin
      tick(1);
      b++;
    end
    check("ack_seen", 32'(n_ack >= target), 32'd1);
  endtask

  task automatic wait_rsp(input int target);
    int b = 0;
    while (n_rsp < target && b < 400) begin
      tick(1);
      b++;
    end
    check("rsp_seen", 32'(n_rsp >= target), 32'd1);
  endtask

  task automatic do_req(input int i, input logic [7:0] op);
    int a0 = n_ack;
    int r0 = n_rsp;
    bus.req_opcode[8*i +: 8] = op;
    bus.req_valid[i] = 1'b1;
    wait_ack(a0 + 1);
    bus.req_valid = '0;
    wait_rsp(r0 + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [1:0] exp_g [3] = '{2'b01, 2'b10, 2'b01};

  initial begin
    int r0, a0, w0, d0, prev_rsp;
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    #3;
    check("rst_apb_ctl", {bus.APBM_PSEL, bus.APBM_PENABLE,
                          bus.APBM_PWRITE}, 0);
    check("rst_paddr", bus.APBM_PADDR, 0);
    check("rst_pwdata", bus.APBM_PWDATA, 0);
    check("rst_ack_rsp", {bus.req_ack, bus.rsp_valid}, 0);
    check("rst_rsp_data", {bus.rsp_status, bus.rsp_error,
                           bus.rsp_timeout}, 0);
    check("rst_seq_busy", bus.seq_busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // single request from requester 0
    prdata = 32'h0000_0000;
    do_req(0, 8'h01);
    check("t1_ack", ack_vec, 2'b01);
    check("t1_wr_addr", wr_addr, 32'h0);
    check("t1_wr_data", wr_data, 32'h01);
    check("t1_rd_addr", rd_addr, 32'h4);
    check("t1_latency", rsp_cyc - ack_cyc, 7);
    check("t1_rsp_vec", rsp_vec, 2'b01);
    check("t1_status", bus.rsp_status, 8'h00);
    check("t1_err_to", {bus.rsp_error, bus.rsp_timeout}, 0);
    check("t1_idle", bus.seq_busy, 0);

    // USR_BUSY held for 50 cycles after the command write
    busy_len = 50;
    prdata   = 32'h0000_00C3;
    do_req(1, 8'h22);
    busy_len = 0;
    check("bw_ack", ack_vec, 2'b10);
    check("bw_wr_data", wr_data, 32'h22);
    check("bw_rd_setup", rd_setup_cyc - wr_cyc, 52);
    check("bw_rsp_vec", rsp_vec, 2'b10);
    check("bw_status", bus.rsp_status, 8'hC3);
    check("bw_err", bus.rsp_error, 0);

    // contention: both held for three transactions
    r0 = n_rsp;
    prev_rsp = 0;
    prdata = 32'h0000_0010;
    bus.req_opcode = 16'hB2A1;
    bus.req_valid  = 2'b11;
    for (int t = 0; t < 3; t++) begin
      wait_rsp(r0 + t + 1);
      check($sformatf("cont_ack%0d", t), ack_vec, exp_g[t]);
      check($sformatf("cont_rsp%0d", t), rsp_vec, exp_g[t]);
      check($sformatf("cont_wd%0d", t), wr_data,
            (t == 1) ? 32'hB2 : 32'hA1);
      if (t > 0) check($sformatf("cont_b2b%0d", t),
                       ack_cyc - prev_rsp, 1);
      prev_rsp = rsp_cyc;
    end
    bus.req_valid = '0;

    // timeout with USR_BUSY stuck high
    busy_stuck = 1'b1;
    prdata = 32'h0000_005A;
    d0 = n_rd;
    do_req(1, 8'h33);
    busy_stuck = 1'b0;
    check("to_latency", rsp_cyc - ack_cyc, 105);
    check("to_read", n_rd - d0, 1);
    check("to_rd_addr", rd_addr, 32'h4);
    check("to_status", bus.rsp_status, 8'h5A);
    check("to_flags", {bus.rsp_error, bus.rsp_timeout}, 2'b11);
    do_req(0, 8'h34);
    check("to_next_lat", rsp_cyc - ack_cyc, 7);
    check("to_next_flags", {bus.rsp_error, bus.rsp_timeout}, 0);

    // PSLVERR on the command write
    pslverr_wr = 1'b1;
    prdata = 32'h0000_0011;
    d0 = n_rd;
    do_req(1, 8'h40);
    pslverr_wr = 1'b0;
    check("slv_read", n_rd - d0, 1);
    check("slv_status", bus.rsp_status, 8'h11);
    check("slv_flags", {bus.rsp_error, bus.rsp_timeout}, 2'b10);

    // USR_CMD_ERROR at status read
    cmd_err = 1'b1;
    prdata  = 32'h0000_0007;
    do_req(0, 8'h41);
    cmd_err = 1'b0;
    check("cmd_status", bus.rsp_status, 8'h07);
    check("cmd_flags", {bus.rsp_error, bus.rsp_timeout}, 2'b10);

    // reset while in BUSY_WAIT
    busy_stuck = 1'b1;
    a0 = n_ack;
    r0 = n_rsp;
    w0 = n_wr;
    bus.req_opcode[15:8] = 8'h44;
    bus.req_valid[1] = 1'b1;
    wait_ack(a0 + 1);
    bus.req_valid = '0;
    check("rbw_gnt", ack_vec, 2'b10);
    tick(8);
    check("rbw_in_wait", n_wr - w0, 1);
    check("rbw_busy", bus.seq_busy, 1);
    rst_n = 1'b0;
    #1;
    check("rbw_seq_busy", bus.seq_busy, 0);
    check("rbw_apb", {bus.APBM_PSEL, bus.APBM_PENABLE,
                      bus.APBM_PWRITE}, 0);
    check("rbw_rsp_data", {bus.rsp_status, bus.rsp_error,
                           bus.rsp_timeout}, 0);
    tick(3);
    busy_stuck = 1'b0;
    rst_n = 1'b1;
    tick(2);
    check("rbw_no_rsp", n_rsp - r0, 0);
    a0 = n_ack;
    r0 = n_rsp;
    bus.req_opcode = 16'h5566;
    bus.req_valid  = 2'b11;
    wait_ack(a0 + 1);
    bus.req_valid = '0;
    check("rbw_first_gnt", ack_vec, 2'b01);
    wait_rsp(r0 + 1);
    check("rbw_rsp_vec", rsp_vec, 2'b01);
    check("rbw_wr_data", wr_data, 32'h66);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
